shared_accum_arbiter: RTL
=========================

// Module: shared_accum_arbiter
// PURPOSE
//  - Shares one ACC_W-bit adder between N_REQ requesters, each owning a private accumulator slot.
//  - Round-robin arbitration. Per-requester valid/ready operand channel; single valid/ready response channel.
//  - Sits between integer producers (int unsigned / int signed operands) and a longint-wide result consumer.
// PARAMETERS
//  N_REQ  2   number of requesters / accumulator slots (>=2)
//  OP_W   32  operand width (int)
//  ACC_W  64  accumulator width (longint); ACC_W > OP_W
// PORTS
//  i_clk        input   1              clock, rising edge
//  i_rst        input   1              reset, asynchronous, active-low
//  i_req_valid  input   [N_REQ]        operand valid per requester
//  i_req_data   input   [N_REQ][OP_W]  operand per requester
//  i_req_signed input   [N_REQ]        1: operand is int signed (sign-extend); 0: int unsigned (zero-extend)
//  o_req_ready  output  [N_REQ]        one-hot accept strobe
//  i_clear      input   1              clear all slots (sampled in IDLE only)
//  o_rsp_valid  output  1              response valid
//  o_rsp_id     output  $clog2(N_REQ)  requester the response belongs to
//  o_rsp_data   output  ACC_W          updated slot value
//  i_rsp_ready  input   1              response accepted
//  o_busy       output  1              state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, all slots=0, rr pointer=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_busy=0, o_req_ready=0.
//  - FSM IDLE -> EXEC -> RESP -> IDLE; no other transitions.
//  - IDLE: i_clear=1 -> all slots<=0, stay IDLE, no grant (clear beats requests).
//    Else if any i_req_valid: winner = first valid at or after rr pointer (wrap at N_REQ).
//    o_req_ready[winner]=1 combinationally this cycle only. Latch data/signed/id -> EXEC.
//  - o_req_ready is 0 in EXEC and RESP. Requesters hold valid/data until ready.
//  - EXEC: slot[id] <= slot[id] + ext(op); o_rsp_data <= same sum; o_rsp_id <= id -> RESP.
//  - RESP: o_rsp_valid=1, data/id stable until i_rsp_ready=1.
//    Then rr pointer <= (id+1) mod N_REQ -> IDLE.
//  - Latency: accept at cycle T -> o_rsp_valid at T+2. Peak throughput 1 op / 3 cycles.
//  - Arithmetic: default is modulo 2^ACC_W wrap. ext() = sign- or zero-extend per latched signed bit.
//  - i_clear outside IDLE is ignored (not deferred).
//  - Reset asserted mid-operation: pending operand and response dropped, slots zeroed.
// CONFIGURATION
//  - SHARED_ACCUM_ARBITER_SAT_EN defined: saturating add.
//    Unsigned op: result clamps to all-ones on carry out.
//    Signed op: slot treated as signed; clamps to 2^(ACC_W-1)-1 on positive overflow, -2^(ACC_W-1) on negative.
//  - Not defined: plain wrap-around add, no saturation logic.
// STRUCTURE
//  - Package shared_accum_pkg: state_e enum {IDLE, EXEC, RESP}; acc_t (ACC_W logic); op_t (OP_W logic).
//  - Package also holds ext_op function (sign/zero extend).
//  - Sub-module rr_arbiter: N_REQ req vector + pointer in -> one-hot grant + encoded id, purely combinational.
//  - Slots: unpacked array acc_t slot [0:N_REQ-1].
// TESTING
//  1 Reset, then req0 unsigned 5 -> ready0 at T, rsp id=0 data=5 at T+2.
//  2 req0 and req1 valid together, ptr=0 -> grant 0 first, then 1; alternation continues while both held.
//  3 req1 signed 32'hFFFF_FFFF (-1) on slot1=3 -> rsp data=2. Same input unsigned -> 3+4294967295=4294967298.
//  4 slot0=64'hFFFF_FFFF_FFFF_FFFF, unsigned +1 -> 0 (wrap). With SAT_EN -> all-ones.
//    With SAT_EN: signed +1 on 64'h7FFF..F -> stays 64'h7FFF..F.
//  5 i_rsp_ready low 4 cycles -> rsp held stable, o_busy=1, no ready to new requests.
//  6 i_clear with req0 valid in IDLE -> slots 0, no grant that cycle.
//    Reset mid-RESP -> o_rsp_valid=0, slots 0.

Source files
------------

// File: rtl/shared_accum_pkg.sv
// Shared types and helpers for the shared-accumulator arbiter.
// Build option: SHARED_ACCUM_ARBITER_SAT_EN selects a saturating add instead of wrap-around.
package shared_accum_pkg;

  localparam int OP_W_DEF  = 32;
  localparam int ACC_W_DEF = 64;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef logic [ACC_W_DEF-1:0] acc_t;
  typedef logic [OP_W_DEF-1:0]  op_t;

  // Widens an operand to accumulator width as int signed or int unsigned.
  function automatic acc_t ext_op(input op_t op, input logic is_signed);
    return {{(ACC_W_DEF-OP_W_DEF){is_signed & op[OP_W_DEF-1]}}, op};
  endfunction

endpackage

// File: rtl/shared_accum_arbiter_rr.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping at N.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id,
  output logic            any
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    id    = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_accum_arbiter.sv
// One adder shared by N_REQ requesters, each with a private accumulator slot, round-robin granted.
// Build option: SHARED_ACCUM_ARBITER_SAT_EN selects a saturating add instead of wrap-around.
module shared_accum_arbiter
  import shared_accum_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int OP_W  = OP_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ-1:0][OP_W-1:0]  i_req_data,
  input  logic [N_REQ-1:0]            i_req_signed,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic                        i_clear,
  output logic                        o_rsp_valid,
  output logic [$clog2(N_REQ)-1:0]    o_rsp_id,
  output logic [ACC_W-1:0]            o_rsp_data,
  input  logic                        i_rsp_ready,
  output logic                        o_busy
);

  localparam int ID_W = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, id_q, win_id;
  logic [OP_W-1:0]   op_q;
  logic              sgn_q;
  logic [ACC_W-1:0]  slot [0:N_REQ-1];
  logic [ACC_W-1:0]  ext_val, sum;
  logic [N_REQ-1:0]  grant;
  logic              any_req, accept, clear_all;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
    .req   (i_req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .id    (win_id),
    .any   (any_req)
  );

  // Grants are suppressed while reset is held so no requester sees a phantom accept.
  always_comb begin
    state_d     = state_q;
    o_req_ready = '0;
    accept      = 1'b0;
    clear_all   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_clear) begin
          clear_all = 1'b1;
        end else if (any_req && i_rst) begin
          o_req_ready = grant;
          accept      = 1'b1;
          state_d     = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ext_val = {{(ACC_W-OP_W){sgn_q & op_q[OP_W-1]}}, op_q};
    sum     = slot[id_q] + ext_val;
`ifdef SHARED_ACCUM_ARBITER_SAT_EN
    if (!sgn_q) begin
      if (sum < slot[id_q]) sum = '1;
    end else if ((slot[id_q][ACC_W-1] == ext_val[ACC_W-1]) &&
                 (sum[ACC_W-1] != ext_val[ACC_W-1])) begin
      sum = ext_val[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  assign o_rsp_valid = (state_q == RESP);
  assign o_busy      = (state_q != IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      op_q       <= '0;
      sgn_q      <= 1'b0;
      o_rsp_id   <= '0;
      o_rsp_data <= '0;
      for (int i = 0; i < N_REQ; i++) slot[i] <= '0;
    end else begin
      state_q <= state_d;
      if (clear_all) begin
        for (int i = 0; i < N_REQ; i++) slot[i] <= '0;
      end
      if (accept) begin
        id_q  <= win_id;
        op_q  <= i_req_data[win_id];
        sgn_q <= i_req_signed[win_id];
      end
      if (state_q == EXEC) begin
        slot[id_q] <= sum;
        o_rsp_data <= sum;
        o_rsp_id   <= id_q;
      end
      // The requester just served drops to lowest priority for the next round.
      if (state_q == RESP && i_rsp_ready) begin
        ptr_q <= (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + 1'b1;
      end
    end
  end

endmodule
